// File: rtl/bus_arbiter4_32bit.sv
// Round-robin arbiter for four 32-bit sources sharing one bus.
// It registers the select, the one-hot grant and the captured data, and caps ownership at MAX_HOLD beats.
module bus_arbiter4_32bit #(
   parameter int MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [3:0]  last,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic [1:0]  sel,
   output logic [3:0]  gnt,
   output logic [31:0] out,
   output logic        out_valid,
   output logic        busy
);

   localparam int CW = $clog2(MAX_HOLD) + 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t         state, state_next;
   logic [1:0]     ptr, ptr_next, sel_next, winner, idx;
   logic [3:0]     gnt_next;
   logic [31:0]    out_next, owner_data;
   logic           out_valid_next, busy_next, found;
   logic [CW-1:0]  hold_cnt, hold_next;

   // Search from ptr upward with wrap, so the most recent owner has lowest priority.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      case (sel)
         2'd0:    owner_data = a;
         2'd1:    owner_data = b;
         2'd2:    owner_data = c;
         default: owner_data = d;
      endcase
   end

   always_comb begin
      state_next     = state;
      ptr_next       = ptr;
      sel_next       = sel;
      gnt_next       = gnt;
      out_next       = out;
      out_valid_next = 1'b0;
      busy_next      = busy;
      hold_next      = hold_cnt;
      case (state)
         IDLE: begin
            if (found) begin
               state_next = OWN;
               gnt_next   = 4'b0001 << winner;
               sel_next   = winner;
               hold_next  = '0;
               busy_next  = 1'b1;
            end
         end
         OWN: begin
            if (req[sel]) begin
               out_next       = owner_data;
               out_valid_next = 1'b1;
               hold_next      = hold_cnt + CW'(1);
            end
            // Release on a dropped request, a final beat or the hold limit; sel is kept.
            if (!req[sel] || last[sel] || (hold_cnt == CW'(MAX_HOLD - 1))) begin
               state_next = IDLE;
               gnt_next   = 4'b0000;
               busy_next  = 1'b0;
               ptr_next   = sel + 2'd1;
               hold_next  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         sel       <= 2'd0;
         gnt       <= 4'b0000;
         out       <= 32'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         sel       <= sel_next;
         gnt       <= gnt_next;
         out       <= out_next;
         out_valid <= out_valid_next;
         busy      <= busy_next;
         hold_cnt  <= hold_next;
      end
   end

endmodule

// File: doc/bus_arbiter4_32bit.md
# bus_arbiter4_32bit

Round-robin arbiter and sequencer for a shared 4-source, 32-bit datapath. Up to four requesters compete for one shared bus; the block grants one at a time and drives the 2-bit source select for the 4:1 32-bit mux. It also registers the selected word onto the bus with a valid strobe. It bounds ownership with a hold limit and sits between the pipeline's write-back/memory sources and the shared register-file write port.

## Interface
- MAX_HOLD, 16, maximum captured beats per grant before forced release (2..256)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  4  request per source; must stay high while the source wants the bus
- last  in  4  final-beat flag per source; only meaningful with that source's req
- a, b, c, d  in  32 each  source data words for sources 0..3
- sel  out  2  registered mux select, equals index of current owner
- gnt  out  4  registered one-hot grant; all-zero when idle
- out  out  32  registered bus data
- out_valid  out  1  high for one cycle per captured beat
- busy  out  1  high while a grant is held (state OWN)

## Operation
- Reset (rst low, any time, asynchronous): state IDLE, ptr=0, gnt=0000, sel=00, out=0, out_valid=0, busy=0, hold_cnt=0. Reset mid-burst aborts the burst with no further beats.
- State machine: IDLE, OWN.
- IDLE: out_valid<=0. If req!=0, winner = first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Next state OWN: gnt<=onehot(winner), sel<=winner, hold_cnt<=0, busy<=1. If req=0, stay IDLE; sel holds its last value.
- OWN, owner o = sel:
  - req[o]=1: beat captured. out<=data[o], out_valid<=1, hold_cnt<=hold_cnt+1.
  - req[o]=1 and last[o]=1: beat captured, then release.
  - req[o]=1 and hold_cnt==MAX_HOLD-1: beat captured, then forced release.
  - req[o]=0: no capture, out_valid<=0, out holds, release.
- Release (same edge): state IDLE, gnt<=0000, busy<=0, ptr<=(o+1) mod 4 (3 wraps to 0), hold_cnt<=0. sel keeps o until the next grant.
- Requests from non-owners during OWN are ignored until the next IDLE cycle. There is no preemption.
- last on a non-owner, or with its req low, has no effect.
- hold_cnt is ceil(log2(MAX_HOLD))+1 bits wide and never wraps because release happens at MAX_HOLD.

## Timing
- Grant latency: req seen in IDLE at edge t gives gnt/sel/busy valid after t (one cycle).
- First beat: captured at edge t+1, with out/out_valid visible after t+1. Beats follow back-to-back at one per cycle while req[o] stays high.
- Owner change: always passes through exactly one IDLE cycle, with gnt=0000 and out_valid=0 in that cycle.
- Fairness: with all four requesting continuously and single-beat bursts, the grant sequence is 0,1,2,3,0,… One beat lands every 2 cycles.
- Any beat captured at edge e shows out_valid=1 for exactly the cycle after e.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single burst: rst released, req=0100 with c=0xC0000001, 0xC0000002, 0xC0000003 on consecutive cycles and last[2] on the third. Expect gnt=0100 and sel=10 one cycle after req, then 3 out_valid pulses carrying those words, then gnt=0000, busy=0, ptr=3.
- Round-robin: req=1111 held, last=1111, a..d=0xA,0xB,0xC,0xD. Expect grants 0001,0010,0100,1000,0001 with an idle cycle between each, and out sequence 0xA,0xB,0xC,0xD,0xA.
- Hold limit: MAX_HOLD=4, req[1] held with last[1]=0, req[3] raised during the burst. Expect exactly 4 beats from b, forced release, one idle cycle, grant 1000, and after source 3 finishes, grant returns to 0010.
- Drop mid-burst: owner 0 lowers req after 2 beats. Expect no third beat, out holding the second word, out_valid=0, gnt=0000 next cycle, ptr=1.
- Wrap and priority: ptr=3 via a completed source-2 burst, then req=1001. Expect source 3 granted first, ptr wrapping to 0, then source 0 granted.
- Async reset: assert rst low mid-burst between clock edges. Expect all outputs at reset values immediately, no beats after rst is released until a new req, and the first grant after reset going to the lowest active index (ptr=0).
